// File: rtl/mem_arb_pkg.sv
// ----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and default widths for the unified-memory arbiter.
//   owner_e          : who owns the read/ack returning in the next cycle
//   DEF_ADDR_WIDTH   : default address width
//   DEF_DATA_WIDTH   : default data width
//   DEF_STARVE_LIMIT : default IF wait limit for the starvation guard build
// ----------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int DEF_ADDR_WIDTH   = 32;
    localparam int DEF_DATA_WIDTH   = 32;
    localparam int DEF_STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D_RD = 2'd2,
        OWN_D_WR = 2'd3
    } owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
// Shares the single-port unified memory between instruction fetch (IF) and
// the LSU. At most one access is granted per cycle (LSU has priority), the
// memory request port is driven combinationally from the granted requester,
// and a one-entry owner register steers the 1-cycle-latency read data / store
// ack back to whoever was granted. A new grant may be issued in the response
// cycle, giving one access per cycle back to back.
//
// Ports
//   clk, rst_n                         clock, synchronous active-low reset
//   if_req_i, if_addr_i                IF read request (held until if_gnt_o)
//   if_gnt_o, if_rvalid_o, if_rdata_o  IF grant and read response
//   d_req_i, d_we_i, d_addr_i,
//   d_wdata_i, d_be_i                  LSU request (held until d_gnt_o)
//   d_gnt_o, d_rvalid_o, d_rdata_o     LSU grant and load data / store ack
//   mem_read_o, mem_write_o,
//   mem_addr_o, mem_wdata_o,
//   mem_byte_en_o                      memory request port
//   mem_rdata_i                        memory read data (cycle after read)
//   mem_ready_i                        memory accepts a request this cycle
//
// Build option
//   MEM_ARB_STARVE_GUARD_EN : when defined, IF is forced ahead of the LSU
//   after STARVE_LIMIT consecutive ready cycles of waiting. When undefined
//   the LSU has strict priority and IF can wait indefinitely.
// ----------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    if_req_i,
    input  logic [ADDR_WIDTH-1:0]   if_addr_i,
    output logic                    if_gnt_o,
    output logic                    if_rvalid_o,
    output logic [DATA_WIDTH-1:0]   if_rdata_o,

    input  logic                    d_req_i,
    input  logic                    d_we_i,
    input  logic [ADDR_WIDTH-1:0]   d_addr_i,
    input  logic [DATA_WIDTH-1:0]   d_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] d_be_i,
    output logic                    d_gnt_o,
    output logic                    d_rvalid_o,
    output logic [DATA_WIDTH-1:0]   d_rdata_o,

    output logic                    mem_read_o,
    output logic                    mem_write_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    output logic [DATA_WIDTH/8-1:0] mem_byte_en_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    input  logic                    mem_ready_i
);

    owner_e r_owner;
    owner_e w_ownerNext;
    logic   w_grantIf;
    logic   w_grantD;
    logic   w_ifStarved;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int CNT_WIDTH = $clog2(STARVE_LIMIT + 1);

    logic [CNT_WIDTH-1:0] r_starveCnt;

    assign w_ifStarved = (r_starveCnt == CNT_WIDTH'(STARVE_LIMIT));

    // Counts ready cycles in which IF waited; any IF grant or a dropped
    // IF request restarts the count, and it holds once the limit is hit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_starveCnt <= '0;
        end else if (!if_req_i || if_gnt_o) begin
            r_starveCnt <= '0;
        end else if (mem_ready_i && !w_ifStarved) begin
            r_starveCnt <= r_starveCnt + 1'b1;
        end
    end
`else
    // Without the guard the limit has no effect.
    logic w_unusedStarveLimit;
    assign w_unusedStarveLimit = (STARVE_LIMIT > 0);
    assign w_ifStarved         = 1'b0;
`endif

    // Owner of the response returning next cycle. Reset drops any response
    // that was in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_owner <= OWN_NONE;
        end else begin
            r_owner <= w_ownerNext;
        end
    end

    // Arbitration: nothing is granted while memory is busy or in reset; the
    // LSU wins a tie unless IF has been starved long enough.
    always_comb begin
        w_grantIf = 1'b0;
        w_grantD  = 1'b0;
        if (rst_n && mem_ready_i) begin
            if (if_req_i && (w_ifStarved || !d_req_i)) begin
                w_grantIf = 1'b1;
            end else if (d_req_i) begin
                w_grantD = 1'b1;
            end
        end
    end

    assign if_gnt_o = w_grantIf;
    assign d_gnt_o  = w_grantD;

    // Memory request port and next owner. Reads always use full byte
    // enables and carry zero write data.
    always_comb begin
        w_ownerNext   = OWN_NONE;
        mem_read_o    = 1'b0;
        mem_write_o   = 1'b0;
        mem_addr_o    = '0;
        mem_wdata_o   = '0;
        mem_byte_en_o = '0;
        if (w_grantIf) begin
            w_ownerNext   = OWN_IF;
            mem_read_o    = 1'b1;
            mem_addr_o    = if_addr_i;
            mem_byte_en_o = '1;
        end else if (w_grantD) begin
            mem_addr_o = d_addr_i;
            if (d_we_i) begin
                w_ownerNext   = OWN_D_WR;
                mem_write_o   = 1'b1;
                mem_wdata_o   = d_wdata_i;
                mem_byte_en_o = d_be_i;
            end else begin
                w_ownerNext   = OWN_D_RD;
                mem_read_o    = 1'b1;
                mem_byte_en_o = '1;
            end
        end
    end

    // Response routing. Gated by rst_n so every output is quiet during the
    // reset cycle; a store ack returns zero data.
    always_comb begin
        if_rvalid_o = 1'b0;
        if_rdata_o  = '0;
        d_rvalid_o  = 1'b0;
        d_rdata_o   = '0;
        if (rst_n) begin
            unique case (r_owner)
                OWN_IF: begin
                    if_rvalid_o = 1'b1;
                    if_rdata_o  = mem_rdata_i;
                end
                OWN_D_RD: begin
                    d_rvalid_o = 1'b1;
                    d_rdata_o  = mem_rdata_i;
                end
                OWN_D_WR: begin
                    d_rvalid_o = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter. The bench plays the memory (a small
// word array answering one cycle after a read) and keeps its own reference:
// a shadow copy of memory, the expected grant from the priority rules and
// the response due next cycle. Directed scenarios come first, followed by
// randomized request traffic with random memory-ready stalls.
// Define MEM_ARB_STARVE_GUARD_EN for both bench and RTL to check the guard.
// ----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int LIMIT = 4;

    logic        clk;
    logic        rst_n;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_gnt_o;
    logic        if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        d_req_i;
    logic        d_we_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic [3:0]  d_be_i;
    logic        d_gnt_o;
    logic        d_rvalid_o;
    logic [31:0] d_rdata_o;
    logic        mem_read_o;
    logic        mem_write_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_byte_en_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ready_i;

    mem_arbiter #(
        .ADDR_WIDTH   (32),
        .DATA_WIDTH   (32),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_req_i      (if_req_i),
        .if_addr_i     (if_addr_i),
        .if_gnt_o      (if_gnt_o),
        .if_rvalid_o   (if_rvalid_o),
        .if_rdata_o    (if_rdata_o),
        .d_req_i       (d_req_i),
        .d_we_i        (d_we_i),
        .d_addr_i      (d_addr_i),
        .d_wdata_i     (d_wdata_i),
        .d_be_i        (d_be_i),
        .d_gnt_o       (d_gnt_o),
        .d_rvalid_o    (d_rvalid_o),
        .d_rdata_o     (d_rdata_o),
        .mem_read_o    (mem_read_o),
        .mem_write_o   (mem_write_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_byte_en_o (mem_byte_en_o),
        .mem_rdata_i   (mem_rdata_i),
        .mem_ready_i   (mem_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Memory device answering the DUT, and the bench's shadow of it.
    logic [31:0] devMem [16];
    logic [31:0] refMem [16];
    bit          devReadPending;
    logic [31:0] devReadData;

    // Reference: response due in the next cycle and IF wait count.
    bit          expIfRv;
    bit          expDRv;
    logic [31:0] expIfData;
    logic [31:0] expDData;
    int          starveCnt;

    // Grants the reference predicted / the DUT gave in the last cycle.
    bit          modelIfGnt;
    bit          modelDGnt;
    bit          dutIfGnt;

    function automatic logic [31:0] mergeBytes(input logic [31:0] oldW,
                                               input logic [31:0] newW,
                                               input logic [3:0]  be);
        logic [31:0] r;
        r = oldW;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[b*8 +: 8] = newW[b*8 +: 8];
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Drives one cycle of inputs (called at negedge), checks every output
    // against the reference, then advances memory and reference at posedge.
    task automatic applyStimulus(input bit rstn, input bit ifReq,
                                 input logic [31:0] ifAddr, input bit dReq,
                                 input bit dWe, input logic [31:0] dAddr,
                                 input logic [31:0] dWdata,
                                 input logic [3:0] dBe, input bit ready);
        bit          gIf, gD, forced;
        bit          oRead, oWrite;
        logic [31:0] oAddr, oWdata;
        logic [3:0]  oBe;
        rst_n       = rstn;
        if_req_i    = ifReq;
        if_addr_i   = ifAddr;
        d_req_i     = dReq;
        d_we_i      = dWe;
        d_addr_i    = dAddr;
        d_wdata_i   = dWdata;
        d_be_i      = dBe;
        mem_ready_i = ready;
        mem_rdata_i = devReadPending ? devReadData : $urandom;
        #1;

`ifdef MEM_ARB_STARVE_GUARD_EN
        forced = (starveCnt >= LIMIT);
`else
        forced = 1'b0;
`endif
        gIf = 1'b0;
        gD  = 1'b0;
        if (rstn && ready) begin
            if (ifReq && (!dReq || forced)) gIf = 1'b1;
            else if (dReq) gD = 1'b1;
        end

        checkOutput("if_gnt", if_gnt_o, gIf);
        checkOutput("d_gnt", d_gnt_o, gD);
        checkOutput("if_rvalid", if_rvalid_o, rstn && expIfRv);
        checkOutput("if_rdata", if_rdata_o, (rstn && expIfRv) ? expIfData : 32'h0);
        checkOutput("d_rvalid", d_rvalid_o, rstn && expDRv);
        checkOutput("d_rdata", d_rdata_o, (rstn && expDRv) ? expDData : 32'h0);
        checkOutput("mem_read", mem_read_o, gIf || (gD && !dWe));
        checkOutput("mem_write", mem_write_o, gD && dWe);
        checkOutput("mem_addr", mem_addr_o, gIf ? ifAddr : (gD ? dAddr : 32'h0));
        if (gD && dWe) begin
            checkOutput("mem_wdata", mem_wdata_o, dWdata);
            checkOutput("mem_be", {28'h0, mem_byte_en_o}, {28'h0, dBe});
        end else if (gIf || gD) begin
            checkOutput("mem_be", {28'h0, mem_byte_en_o}, 32'hF);
        end else begin
            checkOutput("mem_wdata", mem_wdata_o, 32'h0);
            checkOutput("mem_be", {28'h0, mem_byte_en_o}, 32'h0);
        end

        oRead    = mem_read_o;
        oWrite   = mem_write_o;
        oAddr    = mem_addr_o;
        oWdata   = mem_wdata_o;
        oBe      = mem_byte_en_o;
        dutIfGnt = if_gnt_o;

        @(posedge clk);
        devReadPending = oRead;
        devReadData    = devMem[oAddr[5:2]];
        if (oWrite) devMem[oAddr[5:2]] = mergeBytes(devMem[oAddr[5:2]], oWdata, oBe);

        expIfRv   = gIf;
        expIfData = refMem[ifAddr[5:2]];
        expDRv    = gD;
        expDData  = dWe ? 32'h0 : refMem[dAddr[5:2]];
        if (gD && dWe) refMem[dAddr[5:2]] = mergeBytes(refMem[dAddr[5:2]], dWdata, dBe);

        if (!rstn || !ifReq || gIf) starveCnt = 0;
        else if (ready && starveCnt < LIMIT) starveCnt++;

        modelIfGnt = gIf;
        modelDGnt  = gD;
        @(negedge clk);
    endtask

    task automatic idleCycle();
        applyStimulus(1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 1);
    endtask

    initial begin
        bit          ifPend, dPend, dWe;
        logic [31:0] ifAddr, dAddr, dWdata;
        logic [3:0]  dBe;
        int          ifGntCycle;

        rst_n = 0; if_req_i = 0; if_addr_i = 0; d_req_i = 0; d_we_i = 0;
        d_addr_i = 0; d_wdata_i = 0; d_be_i = 0; mem_rdata_i = 0; mem_ready_i = 0;
        for (int i = 0; i < 16; i++) begin
            devMem[i] = 32'h0;
            refMem[i] = 32'h0;
        end
        devMem[4] = 32'hDEADBEEF;
        refMem[4] = 32'hDEADBEEF;
        devReadPending = 0; devReadData = 0;
        expIfRv = 0; expDRv = 0; expIfData = 0; expDData = 0; starveCnt = 0;
        modelIfGnt = 0; modelDGnt = 0; dutIfGnt = 0;

        @(negedge clk);
        $display("[TB] reset");
        applyStimulus(0, 1, 32'h10, 1, 0, 32'h20, 32'h0, 4'hF, 1);
        applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 1);

        $display("[TB] IF only read");
        applyStimulus(1, 1, 32'h10, 0, 0, 32'h0, 32'h0, 4'h0, 1);
        idleCycle();

        $display("[TB] store then load");
        applyStimulus(1, 0, 32'h0, 1, 1, 32'h20, 32'h12345678, 4'b0011, 1);
        applyStimulus(1, 0, 32'h0, 1, 0, 32'h20, 32'h0, 4'h0, 1);
        idleCycle();
        checkOutput("store_load_mem", devMem[8], 32'h00005678);

        $display("[TB] simultaneous requests");
        applyStimulus(1, 1, 32'h14, 1, 0, 32'h10, 32'h0, 4'h0, 1);
        applyStimulus(1, 1, 32'h14, 0, 0, 32'h0, 32'h0, 4'h0, 1);
        idleCycle();

        $display("[TB] memory not ready");
        for (int i = 0; i < 3; i++)
            applyStimulus(1, 1, 32'h18, 1, 1, 32'h24, 32'hA5A5A5A5, 4'hF, 0);
        applyStimulus(1, 1, 32'h18, 1, 1, 32'h24, 32'hA5A5A5A5, 4'hF, 1);
        applyStimulus(1, 1, 32'h18, 0, 0, 32'h0, 32'h0, 4'h0, 1);
        idleCycle();

        $display("[TB] IF against continuous LSU traffic");
        ifGntCycle = -1;
        for (int c = 0; c < 20; c++) begin
            applyStimulus(1, ifGntCycle < 0, 32'h1C, c < 10, 0,
                          32'(c * 4), 32'h0, 4'h0, 1);
            if (dutIfGnt && ifGntCycle < 0) ifGntCycle = c;
        end
`ifdef MEM_ARB_STARVE_GUARD_EN
        checkOutput("starve_gnt_cycle", ifGntCycle, 32'd4);
`else
        checkOutput("starve_gnt_cycle", ifGntCycle, 32'd10);
`endif
        idleCycle();

        $display("[TB] reset mid-operation");
        applyStimulus(1, 1, 32'h10, 0, 0, 32'h0, 32'h0, 4'h0, 1);
        applyStimulus(0, 1, 32'h14, 1, 1, 32'h28, 32'hFFFFFFFF, 4'hF, 1);
        idleCycle();

        $display("[TB] random traffic");
        ifPend = 0; dPend = 0; ifAddr = 0; dAddr = 0; dWdata = 0; dBe = 0; dWe = 0;
        for (int c = 0; c < 600; c++) begin
            if (!ifPend && ($urandom_range(0, 2) == 0)) begin
                ifPend = 1;
                ifAddr = $urandom & 32'hFFFF_FFFC;
            end
            if (!dPend && ($urandom_range(0, 2) != 0)) begin
                dPend  = 1;
                dWe    = $urandom_range(0, 1) == 1;
                dAddr  = $urandom & 32'hFFFF_FFFC;
                dWdata = $urandom;
                dBe    = 4'($urandom);
            end
            applyStimulus(1, ifPend, ifAddr, dPend, dWe, dAddr, dWdata, dBe,
                          $urandom_range(0, 3) != 0);
            if (modelIfGnt) ifPend = 0;
            if (modelDGnt) dPend = 0;
        end
        idleCycle();

        for (int i = 0; i < 16; i++)
            checkOutput("final_mem", devMem[i], refMem[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
